// File: rtl/pipe_stage_if.sv
// Handshake bundle between an upstream producer, the pipe_stage skid buffer and a downstream consumer.
interface pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_halt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_halt;

  // The stage itself: consumes the upstream side, produces the downstream side.
  modport slave (
    input  in_valid, in_data, in_ctrl, in_halt, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, out_halt
  );

  // Whatever surrounds the stage: feeds entries in and drains them out.
  modport master (
    output in_valid, in_data, in_ctrl, in_halt, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, out_halt
  );
endinterface

// File: rtl/pipe_stage.sv
// Two-entry (main + skid) pipeline register with flush/bubble insert and a sticky HALT detector.
// Outputs come straight from the main registers; in_ready depends only on registered state.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         flush,
  pipe_stage_if.slave  bus,
  output logic         halted,
  output logic [1:0]   count
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_halt;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_halt;

  logic accept;
  logic pop;

  assign bus.in_ready  = ~skid_valid & ~halted;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.out_halt  = main_halt;

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = main_valid & bus.out_ready;
  assign count  = {1'b0, main_valid} + {1'b0, skid_valid};

  // ctrl/halt are cleared whenever an entry becomes invalid, so out_ctrl and
  // out_halt read 0 without any output gating.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      main_halt  <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
      skid_halt  <= 1'b0;
      halted     <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_halt  <= 1'b0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_halt  <= 1'b0;
    end else begin
      if (pop && main_halt) begin
        halted <= 1'b1;
      end
      // in_ready is low whenever skid is occupied, so the first branch never
      // coincides with an accept.
      if (pop && skid_valid) begin
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        main_halt  <= skid_halt;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
        skid_halt  <= 1'b0;
      end else if (accept && (!main_valid || pop)) begin
        main_valid <= 1'b1;
        main_data  <= bus.in_data;
        main_ctrl  <= bus.in_ctrl;
        main_halt  <= bus.in_halt;
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= bus.in_data;
        skid_ctrl  <= bus.in_ctrl;
        skid_halt  <= bus.in_halt;
      end else if (pop) begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
        main_halt  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Directed bench for pipe_stage: streaming, backpressure, flush, halt and mid-operation reset.
module tb_pipe_stage;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       flush;
  logic       halted;
  logic [1:0] count;

  int checks   = 0;
  int failures = 0;

  pipe_stage_if #(.DATA_W(32), .CTRL_W(8)) bus ();

  pipe_stage #(.DATA_W(32), .CTRL_W(8)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .flush  (flush),
    .bus    (bus),
    .halted (halted),
    .count  (count)
  );

  always #5 CLK = ~CLK;

  // Drive one upstream entry (or none) plus downstream readiness for the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [7:0] c,
                               input logic h, input logic rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.in_halt   = h;
    bus.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  initial begin
    RST_N = 1'b0;
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 8'd0, 1'b0, 1'b0);
    tick();
    tick();
    RST_N = 1'b1;
    checkOutput("reset_count",     32'(count),         32'd0);
    checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_halted",    32'(halted),        32'd0);
    checkOutput("reset_out_ctrl",  32'(bus.out_ctrl),  32'd0);

    $display("[TB] stream");
    applyStimulus(1'b1, 32'd1, 8'h11, 1'b0, 1'b1);
    tick();
    checkOutput("stream1_data",  bus.out_data,       32'd1);
    checkOutput("stream1_ctrl",  32'(bus.out_ctrl),  32'h11);
    checkOutput("stream1_count", 32'(count),         32'd1);
    checkOutput("stream1_ready", 32'(bus.in_ready),  32'd1);
    applyStimulus(1'b1, 32'd2, 8'h22, 1'b0, 1'b1);
    tick();
    checkOutput("stream2_data",  bus.out_data,       32'd2);
    checkOutput("stream2_count", 32'(count),         32'd1);
    applyStimulus(1'b1, 32'd3, 8'h33, 1'b0, 1'b1);
    tick();
    checkOutput("stream3_data",  bus.out_data,       32'd3);
    checkOutput("stream3_count", 32'(count),         32'd1);
    checkOutput("stream3_ready", 32'(bus.in_ready),  32'd1);
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("stream_drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("stream_drain_ctrl",  32'(bus.out_ctrl),  32'd0);
    checkOutput("stream_drain_count", 32'(count),         32'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
    tick();
    checkOutput("bp_a_count", 32'(count),   32'd1);
    checkOutput("bp_a_data",  bus.out_data, 32'hA);
    applyStimulus(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
    tick();
    checkOutput("bp_ab_count", 32'(count),        32'd2);
    checkOutput("bp_ab_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_ab_data",  bus.out_data,      32'hA);
    applyStimulus(1'b1, 32'hEE, 8'hEE, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold_data",  bus.out_data,      32'hA);
    checkOutput("bp_hold_ctrl",  32'(bus.out_ctrl), 32'h0A);
    checkOutput("bp_hold_count", 32'(count),        32'd2);
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("bp_popa_data",  bus.out_data,      32'hB);
    checkOutput("bp_popa_ctrl",  32'(bus.out_ctrl), 32'h0B);
    checkOutput("bp_popa_count", 32'(count),        32'd1);
    checkOutput("bp_popa_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("bp_popb_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_popb_count", 32'(count),         32'd0);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'hA, 8'h0A, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'hB, 8'h0B, 1'b0, 1'b0);
    tick();
    checkOutput("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1;
    applyStimulus(1'b1, 32'hC, 8'h0C, 1'b0, 1'b1);
    tick();
    checkOutput("fl_count",     32'(count),         32'd0);
    checkOutput("fl_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_out_ctrl",  32'(bus.out_ctrl),  32'd0);
    checkOutput("fl_in_ready",  32'(bus.in_ready),  32'd1);
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("fl_c_dropped", 32'(count), 32'd0);

    $display("[TB] halt");
    applyStimulus(1'b1, 32'h100, 8'h01, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h200, 8'h02, 1'b1, 1'b0);
    tick();
    checkOutput("ht_count",    32'(count),        32'd2);
    checkOutput("ht_x_halt",   32'(bus.out_halt), 32'd0);
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("ht_h_data",   bus.out_data,      32'h200);
    checkOutput("ht_h_halt",   32'(bus.out_halt), 32'd1);
    checkOutput("ht_h_halted", 32'(halted),       32'd0);
    tick();
    checkOutput("ht_halted",   32'(halted),        32'd1);
    checkOutput("ht_ready",    32'(bus.in_ready),  32'd0);
    checkOutput("ht_count0",   32'(count),         32'd0);
    checkOutput("ht_halt_off", 32'(bus.out_halt),  32'd0);
    applyStimulus(1'b1, 32'h300, 8'h03, 1'b0, 1'b1);
    tick();
    checkOutput("ht_y_refused", 32'(bus.out_valid), 32'd0);
    checkOutput("ht_y_count",   32'(count),         32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("ht_flush_keeps", 32'(halted), 32'd1);

    $display("[TB] reset clears halted, flush masks halt pop");
    RST_N = 1'b0;
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b0);
    tick();
    RST_N = 1'b1;
    checkOutput("rs_halted_clr", 32'(halted),       32'd0);
    checkOutput("rs_ready",      32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 32'h400, 8'h04, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h500, 8'h05, 1'b0, 1'b0);
    tick();
    flush = 1'b1;
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    checkOutput("fp_halted", 32'(halted), 32'd0);
    checkOutput("fp_count",  32'(count),  32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 32'h600, 8'h06, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h700, 8'h07, 1'b0, 1'b0);
    tick();
    checkOutput("rm_pre_count", 32'(count), 32'd2);
    RST_N = 1'b0;
    flush = 1'b1;
    applyStimulus(1'b1, 32'h800, 8'h08, 1'b0, 1'b1);
    tick();
    RST_N = 1'b1;
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 8'h00, 1'b0, 1'b0);
    checkOutput("rm_count",     32'(count),         32'd0);
    checkOutput("rm_halted",    32'(halted),        32'd0);
    checkOutput("rm_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rm_out_data",  bus.out_data,       32'd0);
    checkOutput("rm_out_ctrl",  32'(bus.out_ctrl),  32'd0);
    checkOutput("rm_out_halt",  32'(bus.out_halt),  32'd0);
    checkOutput("rm_in_ready",  32'(bus.in_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: payload width (PC/IR/operand/result bundle).
REQ-002 SHALL provide parameter CTRL_W, default 8: control-field width (M/WB-type bits); zeroed on flush.
REQ-003 SHALL provide port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port RST_N  input  1  reset, synchronous, active-low.
REQ-005 SHALL provide port flush  input  1  discard all held entries (bubble insert).
REQ-006 SHALL provide port in_valid  input  1  upstream entry present.
REQ-007 SHALL provide port in_ready  output  1  stage can accept; a function of registered state only.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port in_ctrl  input  CTRL_W  upstream control field.
REQ-010 SHALL provide port in_halt  input  1  entry is a HALT instruction.
REQ-011 SHALL provide port out_valid  output  1  downstream entry present.
REQ-012 SHALL provide port out_ready  input  1  downstream accepts.
REQ-013 SHALL provide port out_data  output  DATA_W  head payload.
REQ-014 SHALL provide port out_ctrl  output  CTRL_W  head control; 0 when out_valid=0.
REQ-015 SHALL provide port out_halt  output  1  head HALT flag; 0 when out_valid=0.
REQ-016 SHALL provide port halted  output  1  sticky: a HALT entry has left the stage.
REQ-017 SHALL provide port count  output  2  entries held (0..2).

Function
REQ-018 SHALL hold two entries, main (head) and skid, each with valid, data, ctrl, halt; output ports come directly from main registers.
REQ-019 SHALL define accept = in_valid & in_ready and pop = out_valid & out_ready.
REQ-020 SHALL drive in_ready = ~skid_valid & ~halted.
REQ-021 SHALL give latency 1: an entry accepted at edge N into an empty stage shows on out_* after edge N.
REQ-022 SHALL sustain one accept and one pop per cycle when out_ready=1 continuously.
REQ-023 SHALL place an accepted entry in main when main is empty or popped this cycle with skid empty; otherwise in skid.
REQ-024 SHALL move skid to main on pop while skid_valid=1; in the same cycle skid_valid clears, and in_ready was 0, so no accept is possible.
REQ-025 SHALL preserve FIFO order; no entry is duplicated or dropped except by flush.
REQ-026 SHALL, on flush=1, clear main and skid valid, ctrl and halt at the next edge, ignore accept and pop that cycle, and leave data don't-care.
REQ-027 SHALL, on flush, not treat a coincident pop as a transfer: halted does not set from it.
REQ-028 SHALL set halted on pop with out_halt=1 and flush=0; halted stays 1 until reset; flush does not clear it.
REQ-029 SHALL keep entries already held while halted=1 drainable by pop.
REQ-030 SHALL keep count = main_valid + skid_valid; skid_valid=1 implies main_valid=1.
REQ-031 SHALL leave out_* unchanged while out_valid=1 and out_ready=0.

Reset
REQ-032 SHALL, when RST_N=0 at an edge, clear main/skid valid, data, ctrl, halt, and halted to 0; count=0, in_ready=1 from the next cycle; reset overrides flush and handshakes.
REQ-033 SHALL, on reset mid-operation, discard held entries without popping them.

Verification
REQ-034 SHALL cover stream: out_ready=1, in_valid=1, data 1,2,3 on consecutive edges -> out_data 1,2,3 one cycle later, count stays 1, in_ready stays 1.
REQ-035 SHALL cover backpressure: out_ready=0, push A,B -> count=2, in_ready=0, out_data=A held; raise out_ready -> A then B, in_ready=1 after A pops.
REQ-036 SHALL cover flush: stage holds A,B, flush=1 with in_valid=1 (C) -> next cycle count=0, out_valid=0, out_ctrl=0, C not captured.
REQ-037 SHALL cover halt: push X(halt=0), H(halt=1), Y -> X, H pop, halted=1 after H, in_ready=0, Y refused; flush leaves halted=1.
REQ-038 SHALL cover reset mid-operation: count=2, RST_N=0 one edge -> count=0, halted=0, all out_*=0, in_ready=1.
